vga_vram_reader: RTL

- Display-side reader for the 80x60 VRAM that the CPU's VGA instruction writes into.
- Generates 640x480@60 Hz VGA timing from the system clock and scales each VRAM cell to an 8x8 screen block.
- Fetches the 3-bit colour word for each cell from the VRAM read port and drives the 1-bit R, G and B pins plus the sync pins.
- Sits between the VRAM read port and the board VGA connector; the CPU writer is never stalled.

---
 rtl/vga_vram_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vga_vram_reader.sv
// Display-side VRAM scanner: 640x480@60 VGA timing, each VRAM cell shown as an 8x8 block.
// The address is registered together with the counters; colour and sync are registered one pixel tick later.
module vga_vram_reader #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int VRAM_W      = 80,
   parameter int VRAM_H      = 60,
   parameter int SCALE_SHIFT = 3,
   parameter int CLK_DIV     = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [12:0] oVRAMReadAddress,
   input  logic [2:0]  iVRAMData,
   output logic        oVGA_R,
   output logic        oVGA_G,
   output logic        oVGA_B,
   output logic        oHSync,
   output logic        oVSync,
   output logic        oFrameStart
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HCW      = $clog2(H_TOTAL);
   localparam int VCW      = $clog2(V_TOTAL);
   localparam int DIVW     = $clog2(CLK_DIV);
   localparam int HS_FIRST = H_VISIBLE + H_FRONT;
   localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
   localparam int VS_FIRST = V_VISIBLE + V_FRONT;
   localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
   localparam int ROW_LAST = (VRAM_H - 1) * VRAM_W;

   function automatic logic [2:0] gate_rgb(input logic [2:0] rgb, input logic en);
      return en ? rgb : 3'b000;
   endfunction

   logic [DIVW-1:0] divider;
   logic            tick;
   logic [HCW-1:0]  h_p0, h_next;
   logic [VCW-1:0]  v_p0, v_next;
   logic [12:0]     row_base_p0, row_base_next, addr_next, addr_p0;
   logic            h_wrap, v_wrap, vld_next;
   logic            vld_p0, hs_p0, vs_p0, fs_p0;
   logic [2:0]      rgb_p1;
   logic            hs_p1, vs_p1, fs_p1;

   assign tick = (divider == DIVW'(CLK_DIV - 1));

   // next scan position; the address is computed for it so it lines up with the counters
   always_comb begin
      h_wrap        = (h_p0 == HCW'(H_TOTAL - 1));
      v_wrap        = h_wrap && (v_p0 == VCW'(V_TOTAL - 1));
      h_next        = h_wrap ? '0 : h_p0 + 1'b1;
      v_next        = v_p0;
      row_base_next = row_base_p0;
      if (v_wrap) begin
         v_next        = '0;
         row_base_next = '0;
      end else if (h_wrap) begin
         v_next = v_p0 + 1'b1;
         if ((v_p0[SCALE_SHIFT-1:0] == '1) && (v_p0 < VCW'(V_VISIBLE - 1)) &&
             (row_base_p0 < 13'(ROW_LAST)))
            row_base_next = row_base_p0 + 13'(VRAM_W);
      end
      vld_next  = (h_next < HCW'(H_VISIBLE)) && (v_next < VCW'(V_VISIBLE));
      addr_next = vld_next ? row_base_next + 13'(h_next >> SCALE_SHIFT) : 13'd0;
   end

   // stage p0: pixel divider, scan counters and VRAM address
   always_ff @(posedge Clock) begin
      if (Reset) begin
         divider     <= '0;
         h_p0        <= '0;
         v_p0        <= '0;
         row_base_p0 <= '0;
         addr_p0     <= '0;
      end else begin
         divider <= tick ? '0 : divider + 1'b1;
         if (tick) begin
            h_p0        <= h_next;
            v_p0        <= v_next;
            row_base_p0 <= row_base_next;
            addr_p0     <= addr_next;
         end
      end
   end

   always_comb begin
      vld_p0 = (h_p0 < HCW'(H_VISIBLE)) && (v_p0 < VCW'(V_VISIBLE));
      hs_p0  = !((h_p0 >= HCW'(HS_FIRST)) && (h_p0 <= HCW'(HS_LAST)));
      vs_p0  = !((v_p0 >= VCW'(VS_FIRST)) && (v_p0 <= VCW'(VS_LAST)));
      fs_p0  = (h_p0 == '0) && (v_p0 == '0);
   end

   // stage p1: RAM data arrives within the tick period; colour and sync leave together
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rgb_p1 <= 3'b000;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
         fs_p1  <= 1'b0;
      end else begin
         fs_p1 <= tick && fs_p0;
         if (tick) begin
            rgb_p1 <= gate_rgb(iVRAMData, vld_p0);
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
         end
      end
   end

   assign oVRAMReadAddress = addr_p0;
   assign oVGA_R           = rgb_p1[2];
   assign oVGA_G           = rgb_p1[1];
   assign oVGA_B           = rgb_p1[0];
   assign oHSync           = hs_p1;
   assign oVSync           = vs_p1;
   assign oFrameStart      = fs_p1;

endmodule
